axis_byte_packer: RTL and testbench

- Upstream stage of the AXI FIFO: packs an 8-bit AXI-Stream byte stream into FIFO_WIDTH-byte words on the FIFO's input interface (data/valid/ready/tuser).
- Marks the first word of every frame on m_tuser.
- Zero-pads the final partial word of a frame and counts completed frames.
- Single clock domain; drives the FIFO write side directly.

---
 rtl/axis_byte_packer.sv | 152 +++++++++++++++
 tb/tb_axis_byte_packer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream byte stream into FIFO_WIDTH-byte words for the FIFO write side.
// The first word of each frame is flagged on m_tuser; short final words are padded with PAD_BYTE.
module axis_byte_packer #(
    parameter int         FIFO_WIDTH = 2,
    parameter logic [7:0] PAD_BYTE   = 8'h00,
    parameter int         CNT_W      = 16
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [7:0]              s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    output logic [8*FIFO_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_tuser,
    output logic [CNT_W-1:0]        frame_cnt
);

    localparam int LANE_W = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
    // A one-byte word needs no pack buffer; one dummy slot keeps the array legal.
    localparam int BUF_N = (FIFO_WIDTH > 1) ? FIFO_WIDTH - 1 : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(FIFO_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_SOF = 1'b0,
        ST_MID = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [7:0]              pack_q [BUF_N];
    logic [7:0]              pack_d [BUF_N];
    logic                    sof_pending_q, sof_pending_d;
    logic [8*FIFO_WIDTH-1:0] m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_tuser_q, m_tuser_d;
    logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;

    logic                    accept;
    logic                    complete;
    logic                    word_sof;
    logic [8*FIFO_WIDTH-1:0] pack_flat;
    logic [8*FIFO_WIDTH-1:0] word;

    assign s_ready   = !m_valid_q || m_ready;
    assign accept    = s_valid && s_ready;
    assign complete  = (lane_q == LAST_LANE) || s_last;
    // The word carries the frame start if its lane-0 byte arrived while in SOF.
    assign word_sof  = (lane_q == {LANE_W{1'b0}}) ? (state_q == ST_SOF) : sof_pending_q;

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_tuser   = m_tuser_q;
    assign frame_cnt = frame_cnt_q;

    // Next-state logic: packing, output slot, frame FSM and frame counter.
    always_comb begin
        pack_d        = pack_q;
        lane_d        = lane_q;
        state_d       = state_q;
        sof_pending_d = sof_pending_q;
        m_data_d      = m_data_q;
        m_tuser_d     = m_tuser_q;
        frame_cnt_d   = frame_cnt_q;
        pack_flat     = {FIFO_WIDTH{PAD_BYTE}};
        word          = {FIFO_WIDTH{PAD_BYTE}};

        for (int j = 0; j < BUF_N; j++) begin
            pack_flat[8*j +: 8] = pack_q[j];
        end
        for (int i = 0; i < FIFO_WIDTH; i++) begin
            if (LANE_W'(i) == lane_q) begin
                word[8*i +: 8] = s_data;
            end else if (LANE_W'(i) < lane_q) begin
                word[8*i +: 8] = pack_flat[8*i +: 8];
            end else begin
                word[8*i +: 8] = PAD_BYTE;
            end
        end

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        if (accept) begin
            if (complete) begin
                m_data_d      = word;
                m_tuser_d     = word_sof;
                m_valid_d     = 1'b1;
                lane_d        = {LANE_W{1'b0}};
                sof_pending_d = 1'b0;
                for (int j = 0; j < BUF_N; j++) begin
                    pack_d[j] = PAD_BYTE;
                end
            end else begin
                for (int j = 0; j < BUF_N; j++) begin
                    if (LANE_W'(j) == lane_q) begin
                        pack_d[j] = s_data;
                    end else begin
                        pack_d[j] = pack_q[j];
                    end
                end
                lane_d        = lane_q + LANE_W'(1);
                sof_pending_d = word_sof;
            end

            case (state_q)
                ST_SOF:  state_d = s_last ? ST_SOF : ST_MID;
                ST_MID:  state_d = s_last ? ST_SOF : ST_MID;
                default: state_d = ST_SOF;
            endcase

            if (s_last) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
        end else begin
            lane_d = lane_q;
        end
    end

    // State registers; reset drops any partial or held word.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SOF;
            lane_q        <= {LANE_W{1'b0}};
            sof_pending_q <= 1'b0;
            m_data_q      <= {(8*FIFO_WIDTH){1'b0}};
            m_valid_q     <= 1'b0;
            m_tuser_q     <= 1'b0;
            frame_cnt_q   <= {CNT_W{1'b0}};
            for (int j = 0; j < BUF_N; j++) begin
                pack_q[j] <= PAD_BYTE;
            end
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            sof_pending_q <= sof_pending_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            m_tuser_q     <= m_tuser_d;
            frame_cnt_q   <= frame_cnt_d;
            pack_q        <= pack_d;
        end
    end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Bench for axis_byte_packer: four instances (W=2, W=4, W=4 with odd pad and 2-bit counter, W=1)
// driven by directed steps; a behavioural model pushes expected words that are popped on handshake.
module tb_axis_byte_packer;

    logic        aclk;
    logic        rst;
    logic        rst_b;
    logic [7:0]  sd [4];
    logic [3:0]  sv, sl, mr, sr, mv, mt;
    logic [15:0] md_a;
    logic [31:0] md_b, md_c;
    logic [7:0]  md_d;
    logic [15:0] fc_a, fc_b, fc_d;
    logic [1:0]  fc_c;

    int vec;
    int miss;
    int last_waits;

    int          wid  [4];
    logic [7:0]  padv [4];
    int          cmod [4];
    int          lane_m [4];
    logic [31:0] word_m [4];
    logic        wsof_m [4];
    logic        sof_st [4];
    int          fcnt_m [4];

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    logic [32:0] q2 [$];
    logic [32:0] q3 [$];

    axis_byte_packer #(.FIFO_WIDTH(2), .PAD_BYTE(8'h00), .CNT_W(16)) dut_a (
        .aclk(aclk), .rst(rst), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(sr[0]), .s_last(sl[0]),
        .m_data(md_a), .m_valid(mv[0]), .m_ready(mr[0]), .m_tuser(mt[0]), .frame_cnt(fc_a));

    axis_byte_packer #(.FIFO_WIDTH(4), .PAD_BYTE(8'h00), .CNT_W(16)) dut_b (
        .aclk(aclk), .rst(rst_b), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(sr[1]), .s_last(sl[1]),
        .m_data(md_b), .m_valid(mv[1]), .m_ready(mr[1]), .m_tuser(mt[1]), .frame_cnt(fc_b));

    axis_byte_packer #(.FIFO_WIDTH(4), .PAD_BYTE(8'hE7), .CNT_W(2)) dut_c (
        .aclk(aclk), .rst(rst), .s_data(sd[2]), .s_valid(sv[2]), .s_ready(sr[2]), .s_last(sl[2]),
        .m_data(md_c), .m_valid(mv[2]), .m_ready(mr[2]), .m_tuser(mt[2]), .frame_cnt(fc_c));

    axis_byte_packer #(.FIFO_WIDTH(1), .PAD_BYTE(8'h00), .CNT_W(16)) dut_d (
        .aclk(aclk), .rst(rst), .s_data(sd[3]), .s_valid(sv[3]), .s_ready(sr[3]), .s_last(sl[3]),
        .m_data(md_d), .m_valid(mv[3]), .m_ready(mr[3]), .m_tuser(mt[3]), .frame_cnt(fc_d));

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] md_of(int d);
        case (d)
            0:       return {16'h0000, md_a};
            1:       return md_b;
            2:       return md_c;
            3:       return {24'h000000, md_d};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] fc_of(int d);
        case (d)
            0:       return {16'h0000, fc_a};
            1:       return {16'h0000, fc_b};
            2:       return {30'h0, fc_c};
            3:       return {16'h0000, fc_d};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int qsize(int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            3:       return q3.size();
            default: return 0;
        endcase
    endfunction

    task automatic qpush(int d, logic [32:0] e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic qpop(int d, output logic [32:0] e);
        case (d)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            2:       e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    task automatic model_reset(int d);
        lane_m[d] = 0;
        word_m[d] = 32'h0;
        wsof_m[d] = 1'b0;
        sof_st[d] = 1'b1;
        fcnt_m[d] = 0;
        case (d)
            0:       q0.delete();
            1:       q1.delete();
            2:       q2.delete();
            default: q3.delete();
        endcase
    endtask

    // Reference packer: called for each byte the DUT accepts.
    task automatic model_byte(int d, logic [7:0] b, logic last);
        if (lane_m[d] == 0) wsof_m[d] = sof_st[d];
        word_m[d][lane_m[d]*8 +: 8] = b;
        if (lane_m[d] == wid[d] - 1 || last) begin
            for (int i = lane_m[d] + 1; i < wid[d]; i++) word_m[d][i*8 +: 8] = padv[d];
            qpush(d, {wsof_m[d], word_m[d]});
            word_m[d] = 32'h0;
            lane_m[d] = 0;
        end else begin
            lane_m[d] = lane_m[d] + 1;
        end
        sof_st[d] = last;
        if (last) fcnt_m[d] = (fcnt_m[d] + 1) % cmod[d];
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [32:0] e;
        for (int d = 0; d < 4; d++) begin
            if (mv[d] && mr[d]) begin
                chk($sformatf("word_expected_d%0d", d), {31'd0, qsize(d) > 0}, 32'd1);
                if (qsize(d) > 0) begin
                    qpop(d, e);
                    chk($sformatf("m_data_d%0d", d), md_of(d), e[31:0]);
                    chk($sformatf("m_tuser_d%0d", d), {31'd0, mt[d]}, {31'd0, e[32]});
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge aclk);
        monitor();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(int d, logic [7:0] b, logic last);
        logic acc;
        int   waits;
        sd[d] = b;
        sv[d] = 1'b1;
        sl[d] = last;
        acc   = 1'b0;
        waits = 0;
        while (!acc && waits < 50) begin
            @(negedge aclk);
            acc = sr[d];
            monitor();
            if (acc) model_byte(d, b, last);
            else waits++;
            @(posedge aclk);
            #1;
        end
        sv[d] = 1'b0;
        sl[d] = 1'b0;
        last_waits = waits;
        chk($sformatf("send_accept_d%0d_%0h", d, b), {31'd0, acc}, 32'd1);
    endtask

    initial begin
        vec = 0;
        miss = 0;
        last_waits = 0;
        wid[0] = 2; wid[1] = 4; wid[2] = 4; wid[3] = 1;
        padv[0] = 8'h00; padv[1] = 8'h00; padv[2] = 8'hE7; padv[3] = 8'h00;
        cmod[0] = 65536; cmod[1] = 65536; cmod[2] = 4; cmod[3] = 65536;
        for (int d = 0; d < 4; d++) begin
            model_reset(d);
            sd[d] = 8'h00;
        end
        sv = 4'b0000;
        sl = 4'b0000;
        mr = 4'b1111;
        rst = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        rst = 1'b0;
        rst_b = 1'b0;
        @(posedge aclk);
        #1;

        // Reset state on every instance
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_m_valid_d%0d", d), {31'd0, mv[d]}, 32'd0);
            chk($sformatf("rst_m_data_d%0d", d), md_of(d), 32'd0);
            chk($sformatf("rst_m_tuser_d%0d", d), {31'd0, mt[d]}, 32'd0);
            chk($sformatf("rst_frame_cnt_d%0d", d), fc_of(d), 32'd0);
            chk($sformatf("rst_s_ready_d%0d", d), {31'd0, sr[d]}, 32'd1);
        end

        // W=2 full frame: 0x2211 (sof) then 0x4433, no back-pressure
        send(0, 8'h11, 1'b0); chk("a_no_stall_11", last_waits, 32'd0);
        send(0, 8'h22, 1'b0); chk("a_no_stall_22", last_waits, 32'd0);
        send(0, 8'h33, 1'b0); chk("a_no_stall_33", last_waits, 32'd0);
        send(0, 8'h44, 1'b1); chk("a_no_stall_44", last_waits, 32'd0);
        repeat (3) cycle();
        chk("a_frame_cnt_1", fc_of(0), 32'd1);

        // W=2 odd-length frame padded, then a single-byte frame
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0);
        send(0, 8'hCC, 1'b1);
        send(0, 8'h55, 1'b1);
        repeat (3) cycle();
        chk("a_frame_cnt_3", fc_of(0), 32'd3);

        // W=2 back-pressure: first word held while byte 33 waits at the source
        mr[0] = 1'b0;
        send(0, 8'h11, 1'b0);
        send(0, 8'h22, 1'b0);
        sd[0] = 8'h33;
        sv[0] = 1'b1;
        sl[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("stall_m_valid", {31'd0, mv[0]}, 32'd1);
            chk("stall_m_data", md_of(0), 32'h0000_2211);
            chk("stall_s_ready", {31'd0, sr[0]}, 32'd0);
            @(posedge aclk);
            #1;
        end
        mr[0] = 1'b1;
        send(0, 8'h33, 1'b0);
        chk("stall_release_same_cycle", last_waits, 32'd0);
        send(0, 8'h44, 1'b1);
        repeat (3) cycle();
        chk("a_frame_cnt_4", fc_of(0), 32'd4);

        // W=4: async reset drops a held word and clears frame_cnt
        send(1, 8'h10, 1'b0);
        send(1, 8'h20, 1'b1);
        send(1, 8'hC1, 1'b0);
        send(1, 8'hC2, 1'b0);
        send(1, 8'hC3, 1'b0);
        send(1, 8'hC4, 1'b0);
        mr[1] = 1'b0;
        chk("b_pre_rst_m_valid", {31'd0, mv[1]}, 32'd1);
        chk("b_pre_rst_frame_cnt", fc_of(1), 32'd1);
        #2 rst_b = 1'b1;
        #1;
        chk("b_rst_m_valid_drop", {31'd0, mv[1]}, 32'd0);
        chk("b_rst_m_data", md_of(1), 32'd0);
        chk("b_rst_frame_cnt", fc_of(1), 32'd0);
        model_reset(1);
        @(negedge aclk);
        rst_b = 1'b0;
        @(posedge aclk);
        #1;
        mr[1] = 1'b1;

        // W=4: reset between edges after 2 of 4 bytes discards the partial word
        send(1, 8'h0A, 1'b0);
        send(1, 8'h0B, 1'b0);
        #2 rst_b = 1'b1;
        #1;
        chk("b_rst2_m_valid", {31'd0, mv[1]}, 32'd0);
        chk("b_rst2_frame_cnt", fc_of(1), 32'd0);
        model_reset(1);
        @(negedge aclk);
        rst_b = 1'b0;
        @(posedge aclk);
        #1;
        send(1, 8'h01, 1'b0);
        send(1, 8'h02, 1'b0);
        send(1, 8'h03, 1'b0);
        send(1, 8'h04, 1'b1);
        repeat (3) cycle();
        chk("b_frame_cnt_after_rst", fc_of(1), 32'd1);

        // CNT_W=2: five single-byte frames, counter wraps 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            send(2, 8'h30 + 8'(i), 1'b1);
            chk($sformatf("c_frame_cnt_%0d", i), fc_of(2), 32'((i + 1) % 4));
        end

        // W=1: only the first word of a frame is flagged
        send(3, 8'h71, 1'b0);
        send(3, 8'h72, 1'b0);
        send(3, 8'h73, 1'b1);
        send(3, 8'h74, 1'b1);

        repeat (5) cycle();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("drain_empty_d%0d", d), qsize(d), 32'd0);
            chk($sformatf("final_frame_cnt_d%0d", d), fc_of(d), 32'(fcnt_m[d]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
